// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM states and the lane/extension/alignment helpers.
package datamem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: byte_en = 4'b0001 << off;
      F3_H, F3_HU: byte_en = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 before extending.
  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   load_extend = {24'h0, sh[7:0]};
      F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   load_extend = {16'h0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = off[0];
      F3_W:        is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/datamem_lsu_ram_be.sv
// Synchronous-read, byte-enable-write word RAM.
module ram_be #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           re,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/datamem_lsu.sv
// Handshaked load/store unit: byte/half/word accesses with extension,
// byte-enable stores, misalignment detection and ALU pass-through.
module datamem_lsu
  import datamem_pkg::*;
#(
  parameter int    ADDRESS_WIDTH = 32,
  parameter int    DATA_WIDTH    = 32,
  parameter int    DEPTH_WORDS   = 256,
  parameter string INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic                     ResultSrc,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     misalign_err
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("datamem_lsu supports DATA_WIDTH=32 only");
  end
  if ((1 << IDXW) != DEPTH_WORDS) begin : g_bad_depth
    $error("datamem_lsu DEPTH_WORDS must be a power of two");
  end

  state_t      state, state_nxt;
  logic        accept, mem_op, err, load_ok;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  // Alignment only matters for real memory operations; pass-through carries arbitrary ALU values.
  assign mem_op     = req_we || ResultSrc;
  assign err        = mem_op && is_misaligned(req_funct3, A[1:0]);
  assign load_ok    = !req_we && ResultSrc && !err;
  assign be         = (accept && rst_n && req_we && !err) ? byte_en(req_funct3, A[1:0]) : 4'b0000;

  always_comb begin
    wdata = WD;
    case (req_funct3)
      F3_B, F3_BU: wdata = {4{WD[7:0]}};
      F3_H, F3_HU: wdata = {2{WD[15:0]}};
      default:     wdata = WD;
    endcase
  end

  ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .re   (accept && load_ok),
    .be   (be),
    .addr (A[IDXW+1:2]),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = load_ok ? LOAD : RESP;
      LOAD:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result/misalign_err only change on the edge that enters RESP, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Result       <= '0;
      misalign_err <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
    end else if (accept) begin
      f3_q  <= req_funct3;
      off_q <= A[1:0];
      if (err) begin
        Result       <= '0;
        misalign_err <= 1'b1;
      end else if (!load_ok) begin
        Result       <= DATA_WIDTH'(A);
        misalign_err <= 1'b0;
      end
    end else if (state == LOAD) begin
      Result       <= load_extend(f3_q, off_q, rdata);
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_datamem_lsu.sv
// Scoreboarded random/directed bench for datamem_lsu against a byte-array memory model.
module tb_datamem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        ResultSrc = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic        resp_valid;
  logic [31:0] Result;
  logic        misalign_err;

  datamem_lsu #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .DEPTH_WORDS  (256),
    .INIT_FILE    ("")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .ResultSrc   (ResultSrc),
    .A           (A),
    .WD          (WD),
    .resp_valid  (resp_valid),
    .Result      (Result),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mbytes [1024];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference: access size from funct3, memory as a flat little-endian byte array.
  function automatic void modelOp(input logic we, input logic [2:0] f3, input logic rs,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] res, output logic err, output int lat);
    int     size;
    bit     sgn;
    bit     illegal;
    longint v;
    size = 4; sgn = 0; illegal = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: illegal = 1;
    endcase
    res = '0; err = 1'b0; lat = 1;
    if (!we && !rs) begin res = a; return; end
    if (illegal || (a % size) != 0) begin err = 1'b1; return; end
    if (we) begin
      for (int k = 0; k < size; k++) mbytes[int'((a + k) % 1024)] = 8'(wd >> (8 * k));
      res = a;
    end else begin
      v = 0;
      for (int k = 0; k < size; k++) v = v | (longint'(mbytes[int'((a + k) % 1024)]) << (8 * k));
      if (sgn && v[8*size-1]) v = v - (longint'(1) << (8 * size));
      res = v[31:0];
      lat = 2;
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic rs,
                               input logic [31:0] a, input logic [31:0] wd);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout actual=0 required=1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; ResultSrc = rs; A = a; WD = wd;
    modelOp(we, f3, rs, a, wd, e.result, e.err, e.due);
    e.due = cyc + e.due;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("ready_busy", {31'b0, req_ready}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_resp actual=1 required=0 result=0x%08h", Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", Result, e.result);
        checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
        checkOutput("latency_cycle", cyc, e.due);
        checkOutput("ready_in_resp", {31'b0, req_ready}, 32'd0);
      end
    end
  end

  initial begin
    logic [2:0]  st_f3 [6];
    logic [2:0]  ld_f3 [8];
    exp_t        e;
    int          waited;
    logic [31:0] a;
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd6};
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset_result", Result, 32'd0);
    checkOutput("reset_err", {31'b0, misalign_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 3'd2, 1'b0, 32'(i * 4), $urandom);

    applyStimulus(1'b1, 3'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd2, 1'b1, 32'h8, 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hB, 32'h0);
    applyStimulus(1'b0, 3'd4, 1'b1, 32'hB, 32'h0);
    applyStimulus(1'b0, 3'd1, 1'b1, 32'hA, 32'h0);
    applyStimulus(1'b0, 3'd5, 1'b1, 32'hA, 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'h8, 32'h0);
    applyStimulus(1'b1, 3'd0, 1'b0, 32'h9, 32'h00000012);
    applyStimulus(1'b1, 3'd1, 1'b0, 32'hA, 32'h00005678);
    applyStimulus(1'b0, 3'd2, 1'b1, 32'h8, 32'h0);
    applyStimulus(1'b0, 3'd2, 1'b1, 32'h408, 32'h0);
    applyStimulus(1'b0, 3'd2, 1'b1, 32'h6, 32'h0);
    applyStimulus(1'b1, 3'd1, 1'b0, 32'h5, 32'hFFFF);
    applyStimulus(1'b0, 3'd2, 1'b1, 32'h4, 32'h0);
    applyStimulus(1'b0, 3'd3, 1'b1, 32'h4, 32'h0);
    applyStimulus(1'b0, 3'd2, 1'b0, 32'h00001234, 32'h0);

    // Valid held across RESP: exactly two accepts in three edges.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; ResultSrc = 1'b0; req_funct3 = 3'd2; A = 32'h00001234;
    for (int k = 0; k < 2; k++) begin
      modelOp(1'b0, 3'd2, 1'b0, 32'h00001234, 32'h0, e.result, e.err, e.due);
      e.due = cyc + 1 + 2 * k;
      sb.push_back(e);
    end
    repeat (3) @(negedge clk);
    req_valid = 1'b0;

    // Reset during LOAD abandons the load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; ResultSrc = 1'b1; req_funct3 = 3'd2; A = 32'h10;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_load_result", Result, 32'd0);
    @(negedge clk);
    checkOutput("rst_load_ready", {31'b0, req_ready}, 32'd1);

    // A store on a reset edge must not be written.
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; ResultSrc = 1'b0; A = 32'h10; WD = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    applyStimulus(1'b0, 3'd2, 1'b1, 32'h10, 32'h0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      case ($urandom_range(0, 9))
        0, 1, 2:       applyStimulus(1'b1, st_f3[$urandom_range(0, 5)], 1'b0, a, $urandom);
        3, 4, 5, 6, 7: applyStimulus(1'b0, ld_f3[$urandom_range(0, 7)], 1'b1, a, $urandom);
        default:       applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'b0, a, $urandom);
      endcase
    end

    waited = 0;
    while (sb.size() > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_pending actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
